// File: rtl/pipe_adder_n.sv
// Pipelined add/subtract unit: WIDTH-bit operation split into STAGES carry-chained slices,
// wrapped in a valid/ready handshake with a single global stall.
module pipe_adder_n #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] add_in1,
  input  logic [WIDTH-1:0] add_in2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SW = WIDTH / STAGES;

  generate
    if ((STAGES < 1) || (STAGES > WIDTH) || (WIDTH % STAGES != 0)) begin : g_bad_params
      $error("pipe_adder_n: WIDTH must be a multiple of STAGES, with 1 <= STAGES <= WIDTH");
    end
  endgenerate

  // Handshake: a transfer happens on a rising edge where valid && ready. Every stage
  // moves together; the pipe advances only when the output slot is empty or being taken.
  logic advance;

  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] cy_q;
  logic [WIDTH-1:0]  acc_q [STAGES];
  logic [WIDTH-1:0]  bop_q [STAGES];
  logic              ovf_q;
  logic              zero_q;

  logic [WIDTH-1:0]  b_eff;
  logic              c0;
  logic [WIDTH-1:0]  a_src [STAGES];
  logic [WIDTH-1:0]  b_src [STAGES];
  logic [STAGES-1:0] c_src;
  logic [STAGES-1:0] stage_in_vld;
  logic [SW:0]       slice_sum [STAGES];
  logic [WIDTH-1:0]  acc_d [STAGES];
  logic [STAGES-1:0] cy_d;
  logic              ovf_d;
  logic              zero_d;

  assign advance = !vld_q[STAGES-1] || out_ready;
  assign b_eff   = sub ? ~add_in2 : add_in2;
  assign c0      = sub ? ~cin : cin;

  // Stage k sees slices [k..] of A/B' still unprocessed; slices below k of acc already hold sum bits.
  always_comb begin
    a_src[0]        = add_in1;
    b_src[0]        = b_eff;
    c_src[0]        = c0;
    stage_in_vld[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_src[k]        = acc_q[k-1];
      b_src[k]        = bop_q[k-1];
      c_src[k]        = cy_q[k-1];
      stage_in_vld[k] = vld_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      slice_sum[k] = {1'b0, a_src[k][k*SW +: SW]} + {1'b0, b_src[k][k*SW +: SW]}
                   + {{SW{1'b0}}, c_src[k]};
      acc_d[k]             = a_src[k];
      acc_d[k][k*SW +: SW] = slice_sum[k][SW-1:0];
      cy_d[k]              = slice_sum[k][SW];
    end
    ovf_d  = (a_src[STAGES-1][WIDTH-1] == b_src[STAGES-1][WIDTH-1]) &&
             (acc_d[STAGES-1][WIDTH-1] != a_src[STAGES-1][WIDTH-1]);
    zero_d = (acc_d[STAGES-1] == '0);
  end

  // Data registers load only for valid slots, so bubbles and reset leave the outputs quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      cy_q   <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        acc_q[k] <= '0;
        bop_q[k] <= '0;
      end
    end else if (advance) begin
      vld_q <= stage_in_vld;
      for (int k = 0; k < STAGES; k++) begin
        if (stage_in_vld[k]) begin
          acc_q[k] <= acc_d[k];
          bop_q[k] <= b_src[k];
          cy_q[k]  <= cy_d[k];
        end
      end
      if (stage_in_vld[STAGES-1]) begin
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  assign in_ready  = advance;
  assign out_valid = vld_q[STAGES-1];
  assign sum       = acc_q[STAGES-1];
  assign cout      = cy_q[STAGES-1];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
